ram_scan_reader: RTL

//  Read-side companion to the switch-driven RAM write path: walks the 256x8 single-port RAM from a

---
 rtl/scan_pkg.sv | 16 +
 rtl/btn_debounce.sv | 40 ++++
 rtl/ram_scan_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and widths for the RAM scan reader and its helpers.
package scan_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    HOLD,
    DONE
  } scan_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> synchronised, debounced level with a one-cycle press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts down the differing samples still needed before level flips
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= CNT_LOAD;
    end else begin
      sync  <= {sync[0], ~raw_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Walks a synchronous-read RAM from start to end address and presents each {addr, data}
// to the display, either on a fixed dwell (AUTO) or one entry per button press (STEP).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a run rising edge
//   ISSUE   | ram_addr presented to the RAM
//   WAIT    | remaining read-latency cycles
//   CAPTURE | ram_q valid; load display registers
//   HOLD    | dwell (AUTO) or wait for press (STEP), then advance or finish
//   DONE    | scan complete; display holds last entry until run drops
module ram_scan_reader
  import scan_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              btn_step_n,
  input  logic              sw_run_n,
  input  logic              sw_auto_n,
  input  logic [ADDR_W-1:0] sw_start,
  input  logic [ADDR_W-1:0] sw_end,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_upd,
  output logic              busy,
  output logic              done
);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  // The CAPTURE cycle counts as the first dwell cycle, so HOLD itself lasts HOLD_CYCLES-1
  // (but never less than one cycle).
  localparam logic [HW-1:0] HOLD_LOAD = (HOLD_CYCLES >= 2) ? HW'(HOLD_CYCLES - 2) : '0;
  localparam logic [1:0]    LAT_LOAD  = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

  scan_state_t       state;
  logic [1:0]        run_sync;
  logic [1:0]        auto_sync;
  logic              run_q;
  logic              press;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_r;
  logic [1:0]        lat_cnt;
  logic [HW-1:0]     hold_cnt;

  assign ram_wren = 1'b0;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk_100M),
    .rst_n (rst_n),
    .raw_n (btn_step_n),
    .press (press)
  );

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_sync  <= 2'b00;
      auto_sync <= 2'b00;
      run_q     <= 1'b0;
      cur       <= '0;
      end_r     <= '0;
      lat_cnt   <= 2'd0;
      hold_cnt  <= '0;
      ram_addr  <= '0;
      disp_addr <= '0;
      disp_data <= '0;
      disp_upd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Switches are inverted into the synchroniser so its flops hold active-high levels.
      run_sync  <= {run_sync[0], ~sw_run_n};
      auto_sync <= {auto_sync[0], ~sw_auto_n};
      run_q     <= run_sync[1];
      disp_upd  <= 1'b0;

      if (state != IDLE && !run_sync[1]) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run_sync[1] && !run_q) begin
              cur      <= sw_start;
              end_r    <= sw_end;
              ram_addr <= sw_start;
              busy     <= 1'b1;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            if (RD_LAT <= 1) begin
              state <= CAPTURE;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (lat_cnt == 2'd0) state <= CAPTURE;
            else                 lat_cnt <= lat_cnt - 2'd1;
          end
          CAPTURE: begin
            disp_data <= ram_q;
            disp_addr <= cur;
            disp_upd  <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
            state     <= HOLD;
          end
          HOLD: begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            if (auto_sync[1] ? (hold_cnt == '0) : press) begin
              if (cur == end_r) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                cur      <= cur + 8'd1;
                ram_addr <= cur + 8'd1;
                state    <= ISSUE;
              end
            end
          end
          DONE: begin
          end
          default: begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
